div_sched_ctrl: RTL and testbench
=================================

// Module: div_sched_ctrl
// PURPOSE
//  Shares one pipeline_division instance between NUM_REQ requesters and sequences it.
//  The divider needs its operands held stable for its full latency, so it takes one
//  operation at a time. This block picks a requester by round-robin and holds the
//  operands for the whole divide. It bypasses divide-by-zero, then returns a tagged result.
// PARAMETERS
//  WIDTH        32  operand/result width; must match the divider's WIDTH
//  NUM_REQ      4   number of requesters (>=2)
//  DIV_LATENCY  8   divider CYCLE; clock edges needed for the result to settle
//  ID_W         2   requester index width, equal to clog2(NUM_REQ)
// PORTS
//  clk            in   1               clock
//  reset          in   1               synchronous, active-high reset
//  req_valid      in   NUM_REQ         per-requester request valid
//  req_ready      out  NUM_REQ         per-requester accept; at most one bit high
//  req_dividend   in   NUM_REQ*WIDTH   packed dividends; requester i uses [i*WIDTH +: WIDTH]
//  req_divisor    in   NUM_REQ*WIDTH   packed divisors, same packing
//  div_dividend   out  WIDTH           divider dividend input (registered)
//  div_divisor    out  WIDTH           divider divisor input (registered)
//  div_quotient   in   WIDTH           divider quotient output
//  div_remainder  in   WIDTH           divider remainder output
//  rsp_valid      out  1               response valid
//  rsp_ready      in   1               response accept
//  rsp_id         out  ID_W            index of the requester that owns the response
//  rsp_quotient   out  WIDTH           quotient
//  rsp_remainder  out  WIDTH           remainder
//  rsp_div_by_zero out 1               divisor was zero
//  busy           out  1               high whenever state != IDLE
//  op_count       out  32              completed responses; wraps modulo 2^32
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, cnt=0. Every registered output resets to 0:
//   div_*, rsp_*, op_count. req_ready=0 during the reset cycle.
//  FSM states: IDLE, RUN, RESP.
//  IDLE:
//   - Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//   - req_ready[winner]=1, driven combinationally from req_valid. All other req_ready bits are 0.
//   - Handshake (valid&ready) on requester w:
//     - latch div_dividend and div_divisor from requester w; rsp_id<=w;
//     - rr_ptr<=(w+1)%NUM_REQ;
//     - if the divisor is 0: rsp_quotient<={WIDTH{1'b1}}, rsp_remainder<=dividend,
//       rsp_div_by_zero<=1, go to RESP;
//     - otherwise: rsp_div_by_zero<=0, cnt<=0, go to RUN.
//   - No valid requester: stay in IDLE; rr_ptr unchanged.
//  RUN:
//   - req_ready=0. div_dividend and div_divisor are held constant.
//   - cnt increments each cycle.
//   - In the cycle where cnt==DIV_LATENCY: capture div_quotient/div_remainder into rsp_*, go to RESP.
//   - RUN therefore lasts exactly DIV_LATENCY+1 cycles.
//  RESP:
//   - rsp_valid=1; all rsp_* held stable; req_ready=0.
//   - On rsp_ready: op_count++ (wrapping), rsp_valid deasserts next cycle, go to IDLE.
//   - No new request is accepted in the same cycle as the response handshake.
//  Latency from request handshake edge to rsp_valid high:
//   - divisor != 0: DIV_LATENCY+2 cycles (10 with defaults);
//   - divisor == 0: 1 cycle, and the divider is not exercised.
//  div_* keep their last values in IDLE and RESP, which avoids needless divider toggling.
//  Arithmetic is unsigned only. No overflow cases exist apart from a zero divisor.
//  rsp_valid is 0 in IDLE and RUN.
//  Reset asserted in any state (including mid-RUN):
//   - the operation is dropped and no response is produced;
//   - the block is in IDLE with reset values on the next cycle;
//   - the divider shares the same reset.
//  Simultaneous requests: exactly one grant per IDLE cycle. Losers keep req_valid high and are
//   served in rotation; any continuously valid requester is granted within NUM_REQ operations.
// TESTING
//  1. Req 2: 100/7 -> req_ready[2] that cycle; rsp_valid 10 cycles later;
//     rsp_id=2, q=14, r=2, dbz=0.
//  2. Req 0: 0x1234/0 -> rsp_valid next cycle; q=0xFFFFFFFF, r=0x1234, dbz=1;
//     div_* never latched nonzero-divisor work.
//  3. All 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0;
//     op_count=5 after the fifth response.
//  4. 0xFFFFFFFF/1, then 5/9 -> q=0xFFFFFFFF r=0, then q=0 r=5.
//     Hold rsp_ready=0 for 6 cycles: rsp_* stable, busy=1, req_ready=0.
//  5. Reset pulsed on RUN cycle 3 -> next cycle IDLE, rsp_valid=0, op_count=0.
//     Following 81/9 returns q=9 r=0.

Source files
------------

// File: rtl/div_sched_if.sv
// Requester/response bundle for the shared-divider scheduler.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high.
// The source holds valid and its payload until then. The sink may drive ready from valid.
interface div_sched_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_dividend;
  logic [NUM_REQ*WIDTH-1:0] req_divisor;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_quotient;
  logic [WIDTH-1:0]         rsp_remainder;
  logic                     rsp_div_by_zero;

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div_by_zero
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div_by_zero
  );
endinterface

// File: rtl/div_sched_ctrl.sv
// Round-robin scheduler that shares one multi-cycle divider among NUM_REQ requesters.
// It holds the operands for the whole divide and short-circuits divide-by-zero.
module div_sched_ctrl #(
  parameter int WIDTH       = 32,
  parameter int NUM_REQ     = 4,
  parameter int DIV_LATENCY = 8,
  parameter int ID_W        = 2
) (
  input  logic             clk,
  input  logic             reset,
  div_sched_if.slave       bus,
  output logic [WIDTH-1:0] div_dividend_o,
  output logic [WIDTH-1:0] div_divisor_o,
  input  logic [WIDTH-1:0] div_quotient_i,
  input  logic [WIDTH-1:0] div_remainder_i,
  output logic             busy_o,
  output logic [31:0]      op_count_o,
  output logic [1:0]       state_o
);
  localparam int CNT_W = $clog2(DIV_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_dividend_q, div_dividend_d;
  logic [WIDTH-1:0] div_divisor_q, div_divisor_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_quotient_q, rsp_quotient_d;
  logic [WIDTH-1:0] rsp_remainder_q, rsp_remainder_d;
  logic             rsp_dbz_q, rsp_dbz_d;
  logic [31:0]      op_count_q, op_count_d;

  logic             found;
  logic [ID_W-1:0]  win_id;
  logic [WIDTH-1:0] win_dividend;
  logic [WIDTH-1:0] win_divisor;
  logic             grant;
  logic             rsp_fire;

  // Scan starts at rr_ptr so the last winner drops to lowest priority.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        win_id = ID_W'(idx);
      end
    end
  end

  assign win_dividend = bus.req_dividend[int'(win_id)*WIDTH +: WIDTH];
  assign win_divisor  = bus.req_divisor[int'(win_id)*WIDTH +: WIDTH];
  assign grant        = (state_q == S_IDLE) && found;
  assign rsp_fire     = (state_q == S_RESP) && bus.rsp_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (found) state_d = (win_divisor == '0) ? S_RESP : S_RUN;
      S_RUN:  if (cnt_q == CNT_W'(DIV_LATENCY)) state_d = S_RESP;
      S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; ready is masked during reset so nothing handshakes then.
  always_comb begin
    bus.req_ready = '0;
    if (grant && !reset) bus.req_ready[win_id] = 1'b1;
    busy_o  = (state_q != S_IDLE);
    state_o = state_q;
  end

  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    cnt_d           = cnt_q;
    div_dividend_d  = div_dividend_q;
    div_divisor_d   = div_divisor_q;
    rsp_id_d        = rsp_id_q;
    rsp_quotient_d  = rsp_quotient_q;
    rsp_remainder_d = rsp_remainder_q;
    rsp_dbz_d       = rsp_dbz_q;
    op_count_d      = op_count_q;
    rsp_valid_d     = (state_d == S_RESP);
    if (grant) begin
      div_dividend_d = win_dividend;
      div_divisor_d  = win_divisor;
      rsp_id_d       = win_id;
      rr_ptr_d       = ID_W'((int'(win_id) + 1) % NUM_REQ);
      cnt_d          = '0;
      if (win_divisor == '0) begin
        rsp_quotient_d  = '1;
        rsp_remainder_d = win_dividend;
        rsp_dbz_d       = 1'b1;
      end else begin
        rsp_dbz_d = 1'b0;
      end
    end
    if (state_q == S_RUN) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DIV_LATENCY)) begin
        rsp_quotient_d  = div_quotient_i;
        rsp_remainder_d = div_remainder_i;
      end
    end
    if (rsp_fire) op_count_d = op_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q        <= '0;
      cnt_q           <= '0;
      div_dividend_q  <= '0;
      div_divisor_q   <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= '0;
      rsp_quotient_q  <= '0;
      rsp_remainder_q <= '0;
      rsp_dbz_q       <= 1'b0;
      op_count_q      <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      cnt_q           <= cnt_d;
      div_dividend_q  <= div_dividend_d;
      div_divisor_q   <= div_divisor_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_id_q        <= rsp_id_d;
      rsp_quotient_q  <= rsp_quotient_d;
      rsp_remainder_q <= rsp_remainder_d;
      rsp_dbz_q       <= rsp_dbz_d;
      op_count_q      <= op_count_d;
    end
  end

  assign div_dividend_o      = div_dividend_q;
  assign div_divisor_o       = div_divisor_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_id          = rsp_id_q;
  assign bus.rsp_quotient    = rsp_quotient_q;
  assign bus.rsp_remainder   = rsp_remainder_q;
  assign bus.rsp_div_by_zero = rsp_dbz_q;
  assign op_count_o          = op_count_q;
endmodule

// File: tb/tb_div_sched_ctrl.sv
// Directed bench for div_sched_ctrl; a behavioural divider pipeline stands in for the real one.
module tb_div_sched_ctrl;
  localparam int WIDTH = 32;
  localparam int NUM_REQ = 4;
  localparam int LAT = 8;
  localparam int ID_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] div_dividend, div_divisor, div_quotient, div_remainder;
  logic             busy;
  logic [31:0]      op_count;
  logic [1:0]       state;

  div_sched_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  div_sched_ctrl #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .DIV_LATENCY(LAT), .ID_W(ID_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus.slave),
    .div_dividend_o  (div_dividend),
    .div_divisor_o   (div_divisor),
    .div_quotient_i  (div_quotient),
    .div_remainder_i (div_remainder),
    .busy_o          (busy),
    .op_count_o      (op_count),
    .state_o         (state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Divider model: result appears LAT edges after the operands change.
  logic [WIDTH-1:0] q_pipe [LAT];
  logic [WIDTH-1:0] r_pipe [LAT];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        q_pipe[i] <= '0;
        r_pipe[i] <= '0;
      end
    end else begin
      q_pipe[0] <= (div_divisor == '0) ? '0 : div_dividend / div_divisor;
      r_pipe[0] <= (div_divisor == '0) ? '0 : div_dividend % div_divisor;
      for (int i = 1; i < LAT; i++) begin
        q_pipe[i] <= q_pipe[i-1];
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end
  assign div_quotient  = q_pipe[LAT-1];
  assign div_remainder = r_pipe[LAT-1];

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [ID_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs);
    bus.req_dividend[i*WIDTH +: WIDTH] = dvd;
    bus.req_divisor[i*WIDTH +: WIDTH]  = dvs;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // Returns cycles from the handshake cycle to the cycle rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    int n = 0;
    while (!bus.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    check("rsp_timeout", {63'd0, bus.rsp_valid}, 64'd1);
    lat = n + 1;
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  logic [WIDTH-1:0] t3_q [NUM_REQ] = '{32'd11, 32'd14, 32'd15, 32'd16};
  logic [WIDTH-1:0] t3_r [NUM_REQ] = '{32'd1, 32'd1, 32'd3, 32'd3};

  initial begin
    int lat;
    bus.req_valid = '0;
    bus.req_dividend = '0;
    bus.req_divisor = '0;
    bus.rsp_ready = 1'b0;

    // reset values, ready masked while reset is high
    reset = 1'b1;
    bus.req_valid = 4'hF;
    tick();
    check("rst_ready", {60'd0, bus.req_ready}, 64'd0);
    do_reset();
    check("rst_state", {62'd0, state}, 64'd0);
    check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("rst_op_count", {32'd0, op_count}, 64'd0);
    check("rst_div_dividend", {32'd0, div_dividend}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);

    // 1: 100/7 from requester 2
    set_req(2, 32'd100, 32'd7);
    #1;
    check("t1_ready", {60'd0, bus.req_ready}, 64'h4);
    tick();
    bus.req_valid = '0;
    check("t1_busy", {63'd0, busy}, 64'd1);
    wait_rsp(lat);
    check("t1_latency", 64'(lat), 64'd10);
    check("t1_id", {62'd0, bus.rsp_id}, 64'd2);
    check("t1_q", {32'd0, bus.rsp_quotient}, 64'd14);
    check("t1_r", {32'd0, bus.rsp_remainder}, 64'd2);
    check("t1_dbz", {63'd0, bus.rsp_div_by_zero}, 64'd0);
    finish_rsp();
    check("t1_rsp_drop", {63'd0, bus.rsp_valid}, 64'd0);
    check("t1_op_count", {32'd0, op_count}, 64'd1);

    // 2: 0x1234/0 from requester 0
    do_reset();
    set_req(0, 32'h1234, 32'd0);
    #1;
    check("t2_ready", {60'd0, bus.req_ready}, 64'h1);
    tick();
    bus.req_valid = '0;
    wait_rsp(lat);
    check("t2_latency", 64'(lat), 64'd1);
    check("t2_q", {32'd0, bus.rsp_quotient}, 64'hFFFF_FFFF);
    check("t2_r", {32'd0, bus.rsp_remainder}, 64'h1234);
    check("t2_dbz", {63'd0, bus.rsp_div_by_zero}, 64'd1);
    check("t2_div_divisor", {32'd0, div_divisor}, 64'd0);
    finish_rsp();

    // 3: all requesters valid, rotation 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, WIDTH'((i + 1) * 20 + 3), WIDTH'(i + 2));
    for (int i = 0; i < 5; i++) exp_q.push_back(ID_W'(i % NUM_REQ));
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [ID_W-1:0] exp_id;
      exp_id = exp_q.pop_front();
      wait_rsp(lat);
      check("t3_id", {62'd0, bus.rsp_id}, {62'd0, exp_id});
      check("t3_q", {32'd0, bus.rsp_quotient}, {32'd0, t3_q[exp_id]});
      check("t3_r", {32'd0, bus.rsp_remainder}, {32'd0, t3_r[exp_id]});
      tick();
    end
    check("t3_op_count", {32'd0, op_count}, 64'd5);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;

    // 4: 0xFFFFFFFF/1 with a stalled response, then 5/9
    do_reset();
    set_req(1, 32'hFFFF_FFFF, 32'd1);
    tick();
    bus.req_valid = '0;
    wait_rsp(lat);
    set_req(3, 32'd5, 32'd9);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t4_hold_q", {32'd0, bus.rsp_quotient}, 64'hFFFF_FFFF);
      check("t4_hold_r", {32'd0, bus.rsp_remainder}, 64'd0);
      check("t4_hold_busy", {63'd0, busy}, 64'd1);
      check("t4_hold_ready", {60'd0, bus.req_ready}, 64'd0);
    end
    finish_rsp();
    check("t4_ready3", {60'd0, bus.req_ready}, 64'h8);
    tick();
    bus.req_valid = '0;
    wait_rsp(lat);
    check("t4_id", {62'd0, bus.rsp_id}, 64'd3);
    check("t4_q", {32'd0, bus.rsp_quotient}, 64'd0);
    check("t4_r", {32'd0, bus.rsp_remainder}, 64'd5);
    finish_rsp();
    check("t4_op_count", {32'd0, op_count}, 64'd2);

    // 5: reset in the middle of a divide
    set_req(0, 32'd50, 32'd5);
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
    check("t5_in_run", {62'd0, state}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_state", {62'd0, state}, 64'd0);
    check("t5_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("t5_op_count", {32'd0, op_count}, 64'd0);
    repeat (12) tick();
    check("t5_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
    set_req(1, 32'd81, 32'd9);
    tick();
    bus.req_valid = '0;
    wait_rsp(lat);
    check("t5_latency", 64'(lat), 64'd10);
    check("t5_q", {32'd0, bus.rsp_quotient}, 64'd9);
    check("t5_r", {32'd0, bus.rsp_remainder}, 64'd0);
    finish_rsp();
    check("t5_op_count_after", {32'd0, op_count}, 64'd1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
